// File: rtl/fb_line_fetch.sv
// Framebuffer-to-linebuffer row fetcher: issues one row of reads per scaled
// display row and writes the returned pixels into the linebuffer.
module fb_line_fetch #(
    parameter int ADDRW  = 16,
    parameter int DATAW  = 4,
    parameter int CORDW  = 16,
    parameter int SCALEW = 6,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame,
    input  logic              line,
    input  logic              line0,
    input  logic [ADDRW-1:0]  base_addr,
    input  logic [ADDRW-1:0]  stride,
    input  logic [CORDW-1:0]  fb_width,
    input  logic [CORDW-1:0]  fb_height,
    input  logic [SCALEW-1:0] scale,
    output logic [ADDRW-1:0]  fb_addr,
    input  logic [DATAW-1:0]  fb_data,
    output logic              lb_we,
    output logic [CORDW-1:0]  lb_x,
    output logic [DATAW-1:0]  lb_data,
    output logic              busy,
    output logic              overrun,
    output logic              done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] FETCH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state, state_nx;
    logic [CORDW-1:0]  cfg_width, cfg_height;
    logic [ADDRW-1:0]  cfg_stride;
    logic [SCALEW-1:0] cfg_scale, scale_m1;
    logic [CORDW-1:0]  row, row_nx, k, k_nx;
    logic [ADDRW-1:0]  row_addr, row_addr_nx;
    logic [SCALEW-1:0] sub, sub_nx;
    logic [CORDW-1:0]  width_eff, height_eff;
    logic              load, issue, step, start, enter_done, overrun_nx;
    logic              done_pend, drained;

    logic [RD_LAT:0]   vld_p;
    logic [CORDW-1:0]  idx_p [RD_LAT+1];

    // True when row r is the final row of a frame of height h (height 0 acts as 1).
    function automatic logic is_last_row(input logic [CORDW-1:0] r, input logic [CORDW-1:0] h);
        return ({1'b0, r} + (CORDW+1)'(1)) >= {1'b0, h};
    endfunction

    assign load       = (state == IDLE) && line0 && !frame;
    assign width_eff  = load ? fb_width : cfg_width;
    assign height_eff = load ? fb_height : cfg_height;
    assign scale_m1   = (cfg_scale == '0) ? '0 : cfg_scale - SCALEW'(1);
    assign drained    = (vld_p[RD_LAT-1:0] == '0);

    always_comb begin
        state_nx    = state;
        row_nx      = row;
        row_addr_nx = row_addr;
        sub_nx      = sub;
        k_nx        = k;
        issue       = 1'b0;
        step        = 1'b0;
        start       = 1'b0;
        enter_done  = 1'b0;
        overrun_nx  = 1'b0;
        if (frame) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (line0) begin
                        row_nx      = '0;
                        sub_nx      = '0;
                        row_addr_nx = base_addr;
                        start       = 1'b1;
                    end
                end
                FETCH: begin
                    if (line) begin
                        overrun_nx = 1'b1;
                        if (is_last_row(row, cfg_height)) enter_done = 1'b1;
                        else                              step       = 1'b1;
                    end else begin
                        issue = 1'b1;
                        k_nx  = k + CORDW'(1);
                        if (({1'b0, k} + (CORDW+1)'(1)) == {1'b0, cfg_width}) begin
                            if (is_last_row(row, cfg_height)) enter_done = 1'b1;
                            else                              state_nx   = WAIT;
                        end
                    end
                end
                WAIT:    step = line;
                default: ;
            endcase

            // A line either repeats the current row or advances to the next one.
            if (step) begin
                if (sub == scale_m1) begin
                    sub_nx      = '0;
                    row_nx      = row + CORDW'(1);
                    row_addr_nx = row_addr + cfg_stride;
                    start       = 1'b1;
                end else begin
                    sub_nx   = sub + SCALEW'(1);
                    state_nx = WAIT;
                end
            end

            // Zero-width rows skip FETCH entirely but still count as fetched.
            if (start) begin
                k_nx = '0;
                if (width_eff == '0) begin
                    if (is_last_row(row_nx, height_eff)) enter_done = 1'b1;
                    else                                 state_nx   = WAIT;
                end else begin
                    state_nx = FETCH;
                end
            end

            if (enter_done) state_nx = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cfg_width  <= '0;
            cfg_height <= '0;
            cfg_stride <= '0;
            cfg_scale  <= '0;
            row        <= '0;
            row_addr   <= '0;
            sub        <= '0;
            k          <= '0;
            done_pend  <= 1'b0;
            fb_addr    <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            done       <= 1'b0;
            vld_p      <= '0;
            for (int i = 0; i <= RD_LAT; i++) idx_p[i] <= '0;
            lb_we      <= 1'b0;
            lb_x       <= '0;
            lb_data    <= '0;
        end else begin
            state    <= state_nx;
            row      <= row_nx;
            row_addr <= row_addr_nx;
            sub      <= sub_nx;
            k        <= k_nx;
            if (load) begin
                cfg_width  <= fb_width;
                cfg_height <= fb_height;
                cfg_stride <= stride;
                cfg_scale  <= scale;
            end
            busy    <= issue;
            overrun <= overrun_nx;
            if (issue) fb_addr <= row_addr + ADDRW'(k);

            // Read-latency stages: tag travels with the outstanding read.
            vld_p    <= frame ? '0 : {vld_p[RD_LAT-1:0], issue};
            idx_p[0] <= k;
            for (int i = 1; i <= RD_LAT; i++) idx_p[i] <= idx_p[i-1];

            // Linebuffer write stage.
            lb_we <= vld_p[RD_LAT] && !frame;
            if (vld_p[RD_LAT]) begin
                lb_x    <= idx_p[RD_LAT];
                lb_data <= fb_data;
            end

            done <= !frame && (state == DONE) && done_pend && drained;
            if (frame)                          done_pend <= 1'b0;
            else if (enter_done)                done_pend <= 1'b1;
            else if (state == DONE && drained)  done_pend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fb_line_fetch.sv
// Bench for fb_line_fetch: table-driven frame scenarios on RD_LAT=1 and RD_LAT=3
// instances, plus hand sequences for reset, idle and async reset mid-fetch.
module tb_fb_line_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame, line, line0;
    logic [15:0] base_addr, stride, fb_width, fb_height;
    logic [5:0]  scale;

    logic [15:0] fb_addr1, lb_x1, fb_addr3, lb_x3;
    logic [3:0]  fb_data1, lb_data1, fb_data3, lb_data3;
    logic        lb_we1, busy1, overrun1, done1;
    logic        lb_we3, busy3, overrun3, done3;
    logic [3:0]  rd3 [3];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    fb_line_fetch #(.ADDRW(16), .DATAW(4), .CORDW(16), .SCALEW(6), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame(frame), .line(line), .line0(line0),
        .base_addr(base_addr), .stride(stride), .fb_width(fb_width), .fb_height(fb_height),
        .scale(scale), .fb_addr(fb_addr1), .fb_data(fb_data1), .lb_we(lb_we1), .lb_x(lb_x1),
        .lb_data(lb_data1), .busy(busy1), .overrun(overrun1), .done(done1));

    fb_line_fetch #(.ADDRW(16), .DATAW(4), .CORDW(16), .SCALEW(6), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .frame(frame), .line(line), .line0(line0),
        .base_addr(base_addr), .stride(stride), .fb_width(fb_width), .fb_height(fb_height),
        .scale(scale), .fb_addr(fb_addr3), .fb_data(fb_data3), .lb_we(lb_we3), .lb_x(lb_x3),
        .lb_data(lb_data3), .busy(busy3), .overrun(overrun3), .done(done3));

    function automatic logic [3:0] pix(input logic [15:0] a);
        return a[3:0] ^ a[7:4];
    endfunction

    // Framebuffer models with 1- and 3-cycle read latency.
    always @(posedge clk) begin
        fb_data1 <= pix(fb_addr1);
        rd3[0]   <= pix(fb_addr3);
        rd3[1]   <= rd3[0];
        rd3[2]   <= rd3[1];
    end
    assign fb_data3 = rd3[2];

    // Per-instance observation state.
    int          nissue [2], nwrite [2], ndone [2], nov [2], nstart [2], align_err [2], wr_at_done [2];
    logic        prev_b [2];
    logic [15:0] row_start [2], last_addr [2];
    logic [15:0] starts [2][3];
    logic        hist_b [2][64];
    logic [15:0] hist_a [2][64], hist_i [2][64];

    task automatic clear_counters();
        for (int d = 0; d < 2; d++) begin
            nissue[d] = 0; nwrite[d] = 0; ndone[d] = 0; nov[d] = 0; nstart[d] = 0;
            align_err[d] = 0; wr_at_done[d] = -1; prev_b[d] = 1'b0;
            row_start[d] = '0; last_addr[d] = '0;
            for (int j = 0; j < 3; j++) starts[d][j] = '0;
        end
    endtask

    task automatic sample(input int d, input int lat, input logic b, input logic [15:0] a,
                          input logic we, input logic [15:0] x, input logic [3:0] dat,
                          input logic ov, input logic dn);
        int hc;
        int hp;
        hc = cyc % 64;
        hp = (cyc + 64 - lat - 1) % 64;
        if (b) begin
            if (!prev_b[d]) begin
                row_start[d] = a;
                if (nstart[d] < 3) starts[d][nstart[d]] = a;
                nstart[d]++;
            end else if (a !== last_addr[d] + 16'd1) begin
                align_err[d]++;
            end
            nissue[d]++;
            last_addr[d] = a;
        end
        hist_b[d][hc] = b;
        hist_a[d][hc] = a;
        hist_i[d][hc] = a - row_start[d];
        prev_b[d] = b;
        if (we) begin
            nwrite[d]++;
            if (!hist_b[d][hp] || x !== hist_i[d][hp] || dat !== pix(hist_a[d][hp]))
                align_err[d]++;
        end
        if (ov) nov[d]++;
        if (dn) begin
            ndone[d]++;
            wr_at_done[d] = nwrite[d];
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        sample(0, 1, busy1, fb_addr1, lb_we1, lb_x1, lb_data1, overrun1, done1);
        sample(1, 3, busy3, fb_addr3, lb_we3, lb_x3, lb_data3, overrun3, done3);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one pulse, sampled at the next rising edge.
    task automatic pulse(input logic l, input logic l0, input logic f);
        line = l; line0 = l0; frame = f;
        @(posedge clk);
        #1;
        line = 1'b0; line0 = 1'b0; frame = 1'b0;
    endtask

    typedef struct packed {
        int w; int h; int sc; int base; int stride; int nlines; int gap; int frame_at;
        int issues; int wr1; int wr3; int ndone; int nov; int nstart;
        int s0; int s1; int s2; int last;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int vi);
        vec_t v;
        int   exp_wr;
        v = vecs[vi];
        fb_width = 16'(v.w); fb_height = 16'(v.h); scale = 6'(v.sc);
        base_addr = 16'(v.base); stride = 16'(v.stride);
        pulse(1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        clear_counters();
        pulse(1'b1, 1'b1, 1'b0);
        if (v.frame_at > 0) begin
            repeat (v.frame_at - 1) @(posedge clk);
            #1;
            pulse(1'b1, 1'b0, 1'b1);
        end else begin
            for (int i = 0; i < v.nlines; i++) begin
                repeat (v.gap - 1) @(posedge clk);
                #1;
                pulse(1'b1, 1'b0, 1'b0);
            end
        end
        repeat (40) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_wr = (d == 0) ? v.wr1 : v.wr3;
            check($sformatf("v%0d.d%0d.issues", vi, d), nissue[d], v.issues);
            check($sformatf("v%0d.d%0d.writes", vi, d), nwrite[d], exp_wr);
            check($sformatf("v%0d.d%0d.done", vi, d), ndone[d], v.ndone);
            check($sformatf("v%0d.d%0d.overrun", vi, d), nov[d], v.nov);
            check($sformatf("v%0d.d%0d.align", vi, d), align_err[d], 0);
            check($sformatf("v%0d.d%0d.rows", vi, d), nstart[d], v.nstart);
            if (v.nstart > 0) check($sformatf("v%0d.d%0d.row0", vi, d), starts[d][0], v.s0);
            if (v.nstart > 1) check($sformatf("v%0d.d%0d.row1", vi, d), starts[d][1], v.s1);
            if (v.nstart > 2) check($sformatf("v%0d.d%0d.row2", vi, d), starts[d][2], v.s2);
            if (v.issues > 0) check($sformatf("v%0d.d%0d.last_addr", vi, d), last_addr[d], v.last);
            if (v.ndone > 0) check($sformatf("v%0d.d%0d.wr_at_done", vi, d), wr_at_done[d], exp_wr);
        end
        check($sformatf("v%0d.busy_end", vi), {busy1, busy3}, 0);
    endtask

    initial begin
        //           w   h  sc base  str  nl gap fr | iss  wr1 wr3 dn ov rows s0   s1   s2   last
        vecs[0] = '{  8, 3, 2, 100,   8,  5, 20, 0,   24,  24, 24, 1, 0, 3,  100, 108, 116, 123};
        vecs[1] = '{  4, 3, 1, 1000, 320, 2, 20, 0,   12,  12, 12, 1, 0, 3, 1000,1320,1640,1643};
        vecs[2] = '{  0, 4, 0, 5,     1,  3, 10, 0,    0,   0,  0, 1, 0, 0,    0,   0,   0,   0};
        vecs[3] = '{  0, 4, 0, 5,     1,  2, 10, 0,    0,   0,  0, 0, 0, 0,    0,   0,   0,   0};
        vecs[4] = '{300, 3, 1, 0,   300,  3,100, 0,  297, 297,297, 1, 3, 3,    0, 300, 600, 698};
        vecs[5] = '{ 20, 3, 1, 0,    20,  1,  0,10,    9,   7,  5, 0, 0, 1,    0,   0,   0,   8};

        rst_n = 1'b1; frame = 1'b0; line = 1'b0; line0 = 1'b0;
        base_addr = '0; stride = '0; fb_width = '0; fb_height = '0; scale = '0;
        clear_counters();
        #2 rst_n = 1'b0;
        #1;
        check("rst.d1.fb_addr", fb_addr1, 0);
        check("rst.d1.lb_x", lb_x1, 0);
        check("rst.d1.ctl", {lb_we1, lb_data1, busy1, overrun1, done1}, 0);
        check("rst.d3.fb_addr", fb_addr3, 0);
        check("rst.d3.lb_x", lb_x3, 0);
        check("rst.d3.ctl", {lb_we3, lb_data3, busy3, overrun3, done3}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // A plain line in IDLE must not start a fetch.
        fb_width = 16'd6; fb_height = 16'd2; scale = 6'd1; base_addr = 16'd40; stride = 16'd6;
        clear_counters();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("idle_line.d1.issues", nissue[0], 0);
        check("idle_line.d3.issues", nissue[1], 0);

        for (int vi = 0; vi < 6; vi++) run_vec(vi);

        // Asynchronous reset in the middle of a fetch.
        fb_width = 16'd50; fb_height = 16'd2; scale = 6'd1; base_addr = 16'd7; stride = 16'd50;
        pulse(1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        pulse(1'b1, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #3;
        check("pre_rst.d1.busy", busy1, 1);
        check("pre_rst.d3.lb_we", lb_we3, 1);
        rst_n = 1'b0;
        #1;
        check("arst.d1.busy", busy1, 0);
        check("arst.d1.fb_addr", fb_addr1, 0);
        check("arst.d1.lb", {lb_we1, lb_x1, lb_data1}, 0);
        check("arst.d3.busy", busy3, 0);
        check("arst.d3.fb_addr", fb_addr3, 0);
        check("arst.d3.lb", {lb_we3, lb_x3, lb_data3}, 0);
        #6;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_counters();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("post_rst.d1.issues", nissue[0], 0);
        check("post_rst.d3.issues", nissue[1], 0);
        pulse(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("restart.d1.busy", busy1, 1);
        check("restart.d1.fb_addr", fb_addr1, 7);
        check("restart.d3.busy", busy3, 1);
        check("restart.d3.fb_addr", fb_addr3, 7);
        pulse(1'b0, 1'b0, 1'b1);
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
